imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the immediate sign-extender: packs an instruction format, opcode, register fields and a 64-bit immediate into a 32-bit LEGv8 instruction word.
- Used by the instruction-memory preloader and the test harness to build programs.
- Feeding its output back through the sign-extender must reproduce the original immediate.
- Two-stage valid/ready pipeline with immediate range checking and status counters.

Parameters:
CNT_W, 16, width of the emitted-word and error counters

Ports:
CLK  input  1  system clock, rising edge
Reset_L  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  encoder can accept a request this cycle
in_fmt  input  3  0=D (LDUR/STUR), 1=CB, 2=B, 3=SHIFT (LSL/LSR), 4=IMM (ADDI/ANDI/ORRI/SUBI); 5-7 illegal
in_opc  input  11  opcode, left-aligned; CB uses [10:3], B uses [10:5], IMM uses [10:1]
in_rd  input  5  Rd/Rt field
in_rn  input  5  Rn field (ignored for CB and B)
in_imm  input  64  immediate in sign-extender output form (byte offsets for CB and B)
out_valid  output  1  encoded word valid
out_ready  input  1  downstream accepts the word
out_instr  output  32  encoded instruction
out_err  output  1  word flagged as unencodable
emit_count  output  CNT_W  words handed off (wraps)
err_count  output  CNT_W  error words handed off (saturates at all-ones)

Behaviour:
- Reset (async, Reset_L=0): both stage valids=0, out_valid=0, out_instr=0, out_err=0, emit_count=0, err_count=0. Any in-flight request is discarded. in_ready=1 in the first cycle after release.
- Stage 1 registers the request and computes a range-check flag.
- Stage 2 holds the packed word and drives out_* directly from flops.
- Latency: 2 cycles from accept to out_valid when there is no backpressure. Throughput: 1 word per cycle.
- Handshake:
  - Transfer happens when valid && ready on the same rising edge.
  - Stage 2 loads when it is empty or out_ready=1.
  - Stage 1 loads when it is empty or stage 2 loads.
  - in_ready = !s1_valid || s2_load.
  - out_* hold stable while out_valid && !out_ready.
  - Simultaneous accept and emit in a cycle is legal, with no bubble. Order is preserved and nothing is dropped or duplicated.
- Range and packing rules. imm is read as signed 64-bit unless stated otherwise:
  - D: imm in [-256,255]. Word = {opc[10:0], imm[8:0], 2'b00, rn, rd}.
  - CB: imm[1:0]==0 and imm/4 in [-2^18, 2^18-1]. Word = {opc[10:3], imm[20:2], rd}.
  - B: imm[1:0]==0 and imm/4 in [-2^25, 2^25-1]. Word = {opc[10:5], imm[27:2]}.
  - SHIFT: unsigned imm in 0..63. Word = {opc[10:0], 5'b0, imm[5:0], rn, rd}.
  - IMM: unsigned imm in 0..4095. Word = {opc[10:1], imm[11:0], rn, rd}.
  - Illegal fmt, or any range failure: out_err=1 and out_instr=32'h0.
- Counters:
  - On each out handshake, emit_count increments, wrapping to 0 after all-ones.
  - If out_err is also 1, err_count increments, saturating at all-ones.
  - Counters never change without a handshake.
- Holding out_ready=0 indefinitely fills both stages, then in_ready=0. Stall depth is 2.

Test Plan:
- D, opc=11'h7C2, rd=9, rn=10, imm=-8 -> out_instr=32'hF85F8149, out_err=0, out_valid exactly 2 cycles after accept.
- CB, opc=11'h5A0, rd=3, imm=16 -> 32'hB4000083. B, opc=11'h0A0, imm=-8 -> 32'h17FFFFFE. Each word fed to the sign-extender returns 16 and -8 respectively.
- IMM, opc=11'h488, rd=1, rn=2, imm=4095 -> 32'h913FFC41. The same request with imm=4096 -> out_instr=0, out_err=1, err_count=1.
- CB with imm=6 (misaligned), SHIFT with imm=64, fmt=7: each -> out_err=1, out_instr=0. err_count ends at 3 and emit_count at 3.
- Backpressure: 4 back-to-back requests with out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts. After release, all 4 words emerge in order, with emit_count=4 and no duplicates.
- Reset_L pulsed low mid-stream with 2 words in flight -> out_valid=0 immediately (asynchronous), counters=0, and no stale word appears after release.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: packs an instruction format, opcode, register fields and a
// 64-bit immediate (in sign-extender output form) into a 32-bit LEGv8 word.
// Two-stage valid/ready pipeline. Stage 1 registers the request along with a
// range-check flag. Stage 2 holds the packed word and drives out_* from flops.
//
// Ports:
//   CLK, Reset_L          clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   request handshake
//   in_fmt                0=D 1=CB 2=B 3=SHIFT 4=IMM, 5-7 illegal
//   in_opc                opcode, left-aligned
//   in_rd, in_rn          register fields
//   in_imm                immediate (byte offsets for CB/B)
//   out_valid / out_ready encoded-word handshake
//   out_instr, out_err    encoded word; err forces the word to zero
//   emit_count            words handed off (wraps)
//   err_count             error words handed off (saturates)
module imm_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [10:0]      in_opc,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rn,
  input  logic [63:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] emit_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    FmtD     = 3'd0,
    FmtCb    = 3'd1,
    FmtB     = 3'd2,
    FmtShift = 3'd3,
    FmtImm   = 3'd4
  } fmt_e;

  // Stage 1 state. Only imm[27:0] is needed for packing once range is known.
  logic        s1_valid_q;
  logic [2:0]  s1_fmt_q;
  logic [10:0] s1_opc_q;
  logic [4:0]  s1_rd_q;
  logic [4:0]  s1_rn_q;
  logic [27:0] s1_imm_q;
  logic        s1_err_q;

  // Stage 2 state.
  logic             s2_valid_q;
  logic [31:0]      s2_instr_q;
  logic             s2_err_q;
  logic [CNT_W-1:0] emit_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic        s1_load;
  logic        s2_load;
  logic        range_ok;
  logic [31:0] packed_word;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Signed ranges hold when all bits above the field's sign bit replicate it.
  always_comb begin
    range_ok = 1'b0;
    case (fmt_e'(in_fmt))
      FmtD:     range_ok = (in_imm[63:8] == {56{in_imm[8]}});
      FmtCb:    range_ok = (in_imm[1:0] == 2'b00) && (in_imm[63:20] == {44{in_imm[20]}});
      FmtB:     range_ok = (in_imm[1:0] == 2'b00) && (in_imm[63:27] == {37{in_imm[27]}});
      FmtShift: range_ok = (in_imm[63:6] == 58'd0);
      FmtImm:   range_ok = (in_imm[63:12] == 52'd0);
      default:  range_ok = 1'b0;
    endcase
  end

  always_comb begin
    packed_word = 32'h0;
    case (fmt_e'(s1_fmt_q))
      FmtD:     packed_word = {s1_opc_q, s1_imm_q[8:0], 2'b00, s1_rn_q, s1_rd_q};
      FmtCb:    packed_word = {s1_opc_q[10:3], s1_imm_q[20:2], s1_rd_q};
      FmtB:     packed_word = {s1_opc_q[10:5], s1_imm_q[27:2]};
      FmtShift: packed_word = {s1_opc_q, 5'b00000, s1_imm_q[5:0], s1_rn_q, s1_rd_q};
      FmtImm:   packed_word = {s1_opc_q[10:1], s1_imm_q[11:0], s1_rn_q, s1_rd_q};
      default:  packed_word = 32'h0;
    endcase
    if (s1_err_q) begin
      packed_word = 32'h0;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      s1_valid_q <= 1'b0;
      s1_fmt_q   <= 3'd0;
      s1_opc_q   <= 11'd0;
      s1_rd_q    <= 5'd0;
      s1_rn_q    <= 5'd0;
      s1_imm_q   <= 28'd0;
      s1_err_q   <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_fmt_q <= in_fmt;
        s1_opc_q <= in_opc;
        s1_rd_q  <= in_rd;
        s1_rn_q  <= in_rn;
        s1_imm_q <= in_imm[27:0];
        s1_err_q <= !range_ok;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      s2_valid_q <= 1'b0;
      s2_instr_q <= 32'h0;
      s2_err_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_q <= packed_word;
        s2_err_q   <= s1_err_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      emit_q    <= '0;
      err_cnt_q <= '0;
    end else if (s2_valid_q && out_ready) begin
      emit_q <= emit_q + CNT_W'(1);
      if (s2_err_q && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_instr  = s2_instr_q;
  assign out_err    = s2_err_q;
  assign emit_count = emit_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder. Expected words are hand-packed constants
// queued on accept and checked in order when the DUT hands a word off.
module tb_imm_encoder;

  localparam int unsigned CW = 16;

  logic          CLK = 1'b0;
  logic          Reset_L = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = 3'd0;
  logic [10:0]   in_opc = 11'd0;
  logic [4:0]    in_rd = 5'd0;
  logic [4:0]    in_rn = 5'd0;
  logic [63:0]   in_imm = 64'd0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [CW-1:0] emit_count;
  logic [CW-1:0] err_count;

  imm_encoder #(.CNT_W(CW)) dut (
    .CLK        (CLK),
    .Reset_L    (Reset_L),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_opc     (in_opc),
    .in_rd      (in_rd),
    .in_rn      (in_rn),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_err    (out_err),
    .emit_count (emit_count),
    .err_count  (err_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  exp_t        exp_next;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_word = 32'h0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] sx_cb(input logic [31:0] w);
    return {{43{w[23]}}, w[23:5], 2'b00};
  endfunction

  function automatic logic [63:0] sx_b(input logic [31:0] w);
    return {{36{w[25]}}, w[25:0], 2'b00};
  endfunction

  // One clock: check any handoff and record any accept at the negedge.
  task automatic tick(output bit acc);
    exp_t e;
    acc = 1'b0;
    @(negedge CLK);
    if (out_valid && out_ready) begin
      chk("word_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_instr", 64'(out_instr), 64'(e.instr));
        chk("out_err", 64'(out_err), 64'(e.err));
        last_word = out_instr;
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(exp_next);
      acc = 1'b1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [10:0] o, input logic [4:0] rd,
                       input logic [4:0] rn, input logic [63:0] imm,
                       input logic [31:0] ei, input logic ee);
    in_valid = 1'b1;
    in_fmt   = f;
    in_opc   = o;
    in_rd    = rd;
    in_rn    = rn;
    in_imm   = imm;
    exp_next = '{err: ee, instr: ei};
  endtask

  task automatic send(input logic [2:0] f, input logic [10:0] o, input logic [4:0] rd,
                      input logic [4:0] rn, input logic [63:0] imm,
                      input logic [31:0] ei, input logic ee);
    bit acc;
    int n;
    n = 0;
    drive(f, o, rd, rn, imm, ei, ee);
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 20);
    chk("accept_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  initial begin
    bit acc;
    int k;

    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_emit", 64'(emit_count), 64'd0);
    chk("rst_errcnt", 64'(err_count), 64'd0);
    @(negedge CLK);
    Reset_L = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // D with latency check
    drive(3'd0, 11'h7C2, 5'd9, 5'd10, -64'sd8, 32'hF85F8149, 1'b0);
    tick(acc);
    chk("d_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    chk("lat_cycle1", 64'(out_valid), 64'd0);
    tick(acc);
    chk("lat_cycle2", 64'(out_valid), 64'd1);
    drain(2);

    // CB and B, round-tripped through a sign-extender model
    send(3'd1, 11'h5A0, 5'd3, 5'd0, 64'd16, 32'hB4000083, 1'b0);
    drain(3);
    chk("cb_sext", sx_cb(last_word), 64'd16);
    send(3'd2, 11'h0A0, 5'd0, 5'd0, -64'sd8, 32'h17FFFFFE, 1'b0);
    drain(3);
    chk("b_sext", sx_b(last_word), -64'sd8);

    // IMM edge and overflow
    send(3'd4, 11'h488, 5'd1, 5'd2, 64'd4095, 32'h913FFC41, 1'b0);
    send(3'd4, 11'h488, 5'd1, 5'd2, 64'd4096, 32'h0, 1'b1);
    drain(3);
    chk("imm_errcnt", 64'(err_count), 64'd1);
    chk("imm_emit", 64'(emit_count), 64'd5);

    // Misaligned CB, shift overflow, illegal fmt
    send(3'd1, 11'h5A0, 5'd3, 5'd0, 64'd6, 32'h0, 1'b1);
    send(3'd3, 11'h69B, 5'd1, 5'd2, 64'd64, 32'h0, 1'b1);
    send(3'd7, 11'h7C2, 5'd9, 5'd10, 64'd0, 32'h0, 1'b1);
    drain(3);
    chk("bad_errcnt", 64'(err_count), 64'd4);
    chk("bad_emit", 64'(emit_count), 64'd8);

    // Legal shift and D range boundaries
    send(3'd3, 11'h69B, 5'd1, 5'd2, 64'd5, 32'hD3601441, 1'b0);
    send(3'd0, 11'h7C2, 5'd9, 5'd10, 64'd255, 32'hF84FF149, 1'b0);
    send(3'd0, 11'h7C2, 5'd9, 5'd10, -64'sd256, 32'hF8500149, 1'b0);
    send(3'd0, 11'h7C2, 5'd9, 5'd10, -64'sd257, 32'h0, 1'b1);
    drain(3);
    chk("bnd_errcnt", 64'(err_count), 64'd5);
    chk("bnd_emit", 64'(emit_count), 64'd12);

    // Backpressure: 4 back-to-back requests, sink stalled 5 cycles
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      if (k < 4) drive(3'd0, 11'h7C0, 5'd2, 5'd1, 64'(k), 32'hF8000022 | (k << 12), 1'b0);
      else in_valid = 1'b0;
      tick(acc);
      if (acc) k++;
    end
    chk("bp_accepts", 64'(k), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_instr", 64'(out_instr), 64'hF8000022);
    chk("bp_emit_stall", 64'(emit_count), 64'd12);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && k < 4; c++) begin
      drive(3'd0, 11'h7C0, 5'd2, 5'd1, 64'(k), 32'hF8000022 | (k << 12), 1'b0);
      tick(acc);
      if (acc) k++;
    end
    chk("bp_all_accepted", 64'(k), 64'd4);
    drain(4);
    chk("bp_emit", 64'(emit_count), 64'd16);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset with two words in flight
    out_ready = 1'b0;
    send(3'd0, 11'h7C0, 5'd2, 5'd1, 64'd7, 32'hF8007022, 1'b0);
    send(3'd0, 11'h7C0, 5'd2, 5'd1, 64'd8, 32'hF8008022, 1'b0);
    chk("inflight_valid", 64'(out_valid), 64'd1);
    #2;
    Reset_L = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_emit", 64'(emit_count), 64'd0);
    chk("arst_errcnt", 64'(err_count), 64'd0);
    chk("arst_instr", 64'(out_instr), 64'd0);
    sb.delete();
    @(negedge CLK);
    Reset_L = 1'b1;
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    drain(5);
    chk("arst_no_stale", 64'(out_valid), 64'd0);
    chk("arst_emit_after", 64'(emit_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
